maze_generator: RTL and testbench
=================================

Name: maze_generator

Overview:
- Produces the wall bitmaps for the playfield: a 10x15 cell maze, generated with the sidewinder algorithm and driven by a 16-bit LFSR.
- Sits upstream of scene_exhibitor and of the top-level movement/collision logic. Both consume `h_walls`/`v_walls` in place of the current hard-wired test pattern.
- Top level pulses `start` with `random_seed` after reset. It holds scene drawing off until `busy` falls.

Parameters:
- WIDTH, 10, maze columns
- HEIGHT, 15, maze rows
- DEFAULT_SEED, 16'hACE1, LFSR load value used when the seed fold is zero

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to generate; sampled only in IDLE
- seed  in  32  random seed, sampled on the cycle `start` is accepted
- busy  out  1  high from the cycle after `start` is accepted until generation is finished
- done  out  1  one-cycle pulse on the cycle `busy` falls
- h_walls  out  WIDTH*(HEIGHT+1)  horizontal walls; bit `y*WIDTH+x` is the top edge of cell (x,y), bit `(y+1)*WIDTH+x` is its bottom edge; 1 = wall
- v_walls  out  (WIDTH+1)*HEIGHT  vertical walls; bit `y*(WIDTH+1)+x` is the left edge of cell (x,y), bit `+1` is its right edge; 1 = wall

Behaviour:
- Reset (`rst`=0, async): state=IDLE, busy=0, done=0, all `h_walls` and `v_walls` bits = 1, lfsr=DEFAULT_SEED.
  - Reset mid-generation aborts immediately to these values.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Advances exactly once per clock while state != IDLE; holds in IDLE.
  - Load value on start: `seed[31:16] ^ seed[15:0]`, or DEFAULT_SEED if that fold is 0.
- `start` while busy is ignored; no queueing. Wall outputs change only while busy and are stable whenever busy=0.
- States:
  - IDLE: on `start`=1, go to INIT. busy=1 from the next cycle.
  - INIT (1 cycle):
    - Set all wall bits to 1, then clear `v_walls[x+1]` for x=0..WIDTH-2, so row 0 is one open corridor.
    - Set y=1, x=0, run_start=0. Go to CELL.
  - CELL (1 cycle per cell):
    - If x<WIDTH-1 and lfsr[0]=1: clear `v_walls[y*(WIDTH+1)+x+1]`, then x=x+1.
    - Otherwise: go to PICK with run_len = x-run_start+1 and tries=0.
  - PICK (1+ cycles):
    - k=lfsr[3:0]. If k<run_len, or tries=7 (then force k=0): clear `h_walls[y*WIDTH+run_start+k]` and set run_start=x+1.
      - If x<WIDTH-1: x=x+1, go to CELL.
      - Else if y<HEIGHT-1: y=y+1, x=0, run_start=0, go to CELL.
      - Else: go to DONE.
    - Otherwise (k>=run_len and tries<7): tries=tries+1, stay in PICK.
  - DONE (1 cycle): done=1, busy=0 on the next edge, return to IDLE.
- Invariants of the result:
  - All border bits stay 1: h rows 0 and HEIGHT, v columns 0 and WIDTH.
  - Exactly WIDTH*HEIGHT-1 = 149 interior walls are cleared, and the cells form a spanning tree.
  - Every row y>=1 has at least one upward opening per run.
- Latency from `start` to `done`:
  - Minimum is 1 + 14*10 + (number of runs) + 1 cycles.
  - Maximum adds 7 extra PICK cycles per run. Worst case is bounded at 1+140+140*8+1 = 1262 cycles.
- Determinism: the same seed always yields identical bitmaps and identical cycle count.

Test Plan:
- Reset with no start -> busy=0, done=0, all 160 `h_walls` bits = 1, all 165 `v_walls` bits = 1.
- start with seed=32'h0000_1234 -> done pulses once, cycle count <= 1262. Borders all 1; `v_walls[1..9]`=0; exactly 149 interior bits are 0; BFS from cell (0,0) reaches all 150 cells.
- Run seed=32'h0000_1234 twice, and seed=32'h1234_0000 once -> all three bitmaps are bit-identical with identical latency. Seed=32'h5A5A_5A5A (fold=0) matches a run whose fold equals 16'hACE1.
- Pulse start again 20 cycles into generation -> ignored; the result equals a single uninterrupted run.
- Assert rst=0 at cycle 50 of generation -> busy=0 and all walls = 1 asynchronously. A new start with the same seed then produces the reference result.
- Force the LFSR into a state where lfsr[3:0]>=run_len for 8 cycles (testbench override) -> PICK clears `h_walls[y*10+run_start]` on the 8th cycle.

Source files
------------

// File: rtl/maze_generator_if.sv
// Handshake and wall-bitmap bundle between the maze generator and its consumers.
// The slave side is the generator; the master side requests mazes and reads the walls.
interface maze_generator_if #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 15
);
  logic                             start;
  logic [31:0]                      seed;
  logic                             busy;
  logic                             done;
  logic [WIDTH*(HEIGHT+1)-1:0]      h_walls;
  logic [(WIDTH+1)*HEIGHT-1:0]      v_walls;

  modport master (
    output start, seed,
    input  busy, done, h_walls, v_walls
  );

  modport slave (
    input  start, seed,
    output busy, done, h_walls, v_walls
  );
endinterface

// File: rtl/maze_generator.sv
// Sidewinder maze generator: carves a WIDTH x HEIGHT maze into wall bitmaps,
// taking its random choices from a 16-bit Fibonacci LFSR seeded on start.
module maze_generator #(
  parameter int          WIDTH        = 10,
  parameter int          HEIGHT       = 15,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input logic            clk,
  input logic            rst,
  maze_generator_if.slave bus
);

  localparam int HW  = WIDTH * (HEIGHT + 1);
  localparam int VW  = (WIDTH + 1) * HEIGHT;
  localparam int HIW = $clog2(HW);
  localparam int VIW = $clog2(VW);
  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CELL,
    S_PICK,
    S_DONE
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_next;
  logic [15:0]     fold;
  logic [7:0]      x;
  logic [7:0]      y;
  logic [7:0]      run_start;
  logic [2:0]      tries;
  logic [HW-1:0]   h_q;
  logic [VW-1:0]   v_q;
  logic [7:0]      run_len;
  logic [7:0]      pick_k;
  logic            pick_take;
  logic            carve_east;
  logic [HIW-1:0]  h_idx;
  logic [VIW-1:0]  v_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Run bookkeeping: the current run spans run_start..x, and a PICK that misses
  // seven times in a row falls back to the run's first cell.
  always_comb begin
    next_state = state;
    lfsr_next  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    fold       = bus.seed[31:16] ^ bus.seed[15:0];
    run_len    = x - run_start + 8'd1;
    carve_east = (x < X_LAST) && lfsr[0];
    pick_take  = ({4'b0, lfsr[3:0]} < run_len) || (tries == 3'd7);
    pick_k     = ({4'b0, lfsr[3:0]} < run_len) ? {4'b0, lfsr[3:0]} : 8'd0;
    h_idx      = HIW'(32'(y) * WIDTH + 32'(run_start) + 32'(pick_k));
    v_idx      = VIW'(32'(y) * (WIDTH + 1) + 32'(x) + 1);
    bus.busy   = (state == S_INIT) || (state == S_CELL) || (state == S_PICK);
    bus.done   = (state == S_DONE);
    bus.h_walls = h_q;
    bus.v_walls = v_q;
    case (state)
      S_IDLE: if (bus.start) next_state = S_INIT;
      S_INIT: next_state = S_CELL;
      S_CELL: if (!carve_east) next_state = S_PICK;
      S_PICK: begin
        if (pick_take) begin
          if (x < X_LAST || y < Y_LAST) next_state = S_CELL;
          else                          next_state = S_DONE;
        end
      end
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr      <= DEFAULT_SEED;
      h_q       <= '1;
      v_q       <= '1;
      x         <= '0;
      y         <= '0;
      run_start <= '0;
      tries     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) lfsr <= (fold == 16'h0) ? DEFAULT_SEED : fold;
        end
        S_INIT: begin
          lfsr <= lfsr_next;
          h_q  <= '1;
          v_q  <= '1;
          // Row 0 becomes a single corridor open along its whole length.
          for (int i = 1; i < WIDTH; i++) v_q[i] <= 1'b0;
          x         <= 8'd0;
          y         <= 8'd1;
          run_start <= 8'd0;
          tries     <= 3'd0;
        end
        S_CELL: begin
          lfsr <= lfsr_next;
          if (carve_east) begin
            v_q[v_idx] <= 1'b0;
            x          <= x + 8'd1;
          end else begin
            tries <= 3'd0;
          end
        end
        S_PICK: begin
          lfsr <= lfsr_next;
          if (pick_take) begin
            h_q[h_idx] <= 1'b0;
            run_start  <= x + 8'd1;
            tries      <= 3'd0;
            if (x < X_LAST) begin
              x <= x + 8'd1;
            end else if (y < Y_LAST) begin
              y         <= y + 8'd1;
              x         <= 8'd0;
              run_start <= 8'd0;
            end
          end else begin
            tries <= tries + 3'd1;
          end
        end
        S_DONE: lfsr <= lfsr_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_generator.sv
// Self-checking bench for maze_generator: table-driven and random seeds against a
// sidewinder reference model, plus restart, mid-run reset and forced-pick sequences.
module tb_maze_generator;

  localparam int W = 10;
  localparam int H = 15;

  typedef struct {
    logic [31:0] seed;
    logic [15:0] load;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vecs[6];

  maze_generator_if #(.WIDTH(W), .HEIGHT(H)) bus ();

  maze_generator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // Sidewinder played directly off a stream of random draws, one draw per clock.
  task automatic model_run(input logic [15:0] load, output logic [159:0] h, output logic [164:0] v,
                           output int steps, output int ev_cycle, output int ev_bit);
    logic [15:0] l;
    int rs, rl, k;
    l = load; steps = 0; ev_cycle = -1; ev_bit = -1;
    h = '1; v = '1;
    for (int i = 1; i < W; i++) v[i] = 1'b0;
    l = lfsr_step(l); steps++;
    for (int y = 1; y < H; y++) begin
      rs = 0;
      for (int x = 0; x < W; x++) begin
        logic b;
        b = l[0];
        l = lfsr_step(l); steps++;
        if (x < W - 1 && b) begin
          v[y*(W+1)+x+1] = 1'b0;
          continue;
        end
        rl = x - rs + 1;
        for (int t = 0; t < 8; t++) begin
          k = int'(l[3:0]);
          l = lfsr_step(l); steps++;
          if (k < rl) begin
            h[y*W+rs+k] = 1'b0;
            break;
          end else if (t == 7) begin
            h[y*W+rs] = 1'b0;
            if (ev_cycle < 0) begin
              ev_cycle = steps - 1;
              ev_bit   = y*W + rs;
            end
          end
        end
        rs = x + 1;
      end
    end
    steps++;
  endtask

  function automatic int reach_count(input logic [159:0] h, input logic [164:0] v);
    bit seen[W*H];
    int q[$];
    int c, x, y, n;
    for (int i = 0; i < W*H; i++) seen[i] = 1'b0;
    seen[0] = 1'b1; q.push_back(0); n = 0;
    while (q.size() > 0) begin
      c = q.pop_front(); n++; x = c % W; y = c / W;
      if (x < W-1 && !v[y*(W+1)+x+1] && !seen[c+1]) begin seen[c+1] = 1'b1; q.push_back(c+1); end
      if (x > 0   && !v[y*(W+1)+x]   && !seen[c-1]) begin seen[c-1] = 1'b1; q.push_back(c-1); end
      if (y < H-1 && !h[(y+1)*W+x]   && !seen[c+W]) begin seen[c+W] = 1'b1; q.push_back(c+W); end
      if (y > 0   && !h[y*W+x]       && !seen[c-W]) begin seen[c-W] = 1'b1; q.push_back(c-W); end
    end
    return n;
  endfunction

  // One generation from start to done; optionally re-pulses start mid-run and
  // watches one h_walls bit around the cycle a forced pick should clear it.
  task automatic apply_stimulus(input logic [31:0] s, input int restart_at, input int watch_c,
                                input int watch_b, output logic [159:0] h, output logic [164:0] v,
                                output int cyc);
    int busy_lo;
    bit got;
    @(negedge clk);
    bus.seed = s; bus.start = 1'b1;
    cyc = 0; busy_lo = 0; got = 1'b0;
    while (cyc < 2000 && !got) begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
      if (cyc == restart_at) begin
        bus.seed = 32'hDEAD_BEEF; bus.start = 1'b1;
      end
      if (watch_c >= 0 && cyc == watch_c + 1) check_output("forced_pick_before", bus.h_walls[watch_b], 1);
      if (watch_c >= 0 && cyc == watch_c + 2) check_output("forced_pick_cleared", bus.h_walls[watch_b], 0);
      if (bus.done) got = 1'b1;
      else if (!bus.busy) busy_lo++;
    end
    check_output("done_within_bound", got, 1);
    check_output("busy_held", busy_lo, 0);
    h = bus.h_walls; v = bus.v_walls;
    @(negedge clk);
    check_output("done_one_pulse", {bus.done, bus.busy}, 0);
  endtask

  initial begin
    logic [159:0] h, mh;
    logic [164:0] v, mv;
    logic [14:0]  vl, vr;
    logic [31:0]  s;
    logic [15:0]  ld;
    int cyc, msteps, evc, evb;

    n_checks = 0; n_fail = 0;
    vecs[0] = '{32'h0000_1234, 16'h1234};
    vecs[1] = '{32'h0000_1234, 16'h1234};
    vecs[2] = '{32'h1234_0000, 16'h1234};
    vecs[3] = '{32'h5A5A_5A5A, 16'hACE1};
    vecs[4] = '{32'h0000_ACE1, 16'hACE1};
    vecs[5] = '{32'h1111_BDF0, 16'hACE1};

    rst = 1'b0; bus.start = 1'b0; bus.seed = '0;
    repeat (3) @(negedge clk);
    check_output("reset_busy_done", {bus.busy, bus.done}, 0);
    check_output("reset_h_walls", bus.h_walls, {160{1'b1}});
    check_output("reset_v_walls", bus.v_walls, {165{1'b1}});
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      model_run(vecs[i].load, mh, mv, msteps, evc, evb);
      apply_stimulus(vecs[i].seed, -1, evc, evb, h, v, cyc);
      check_output($sformatf("vec%0d_h_walls", i), h, mh);
      check_output($sformatf("vec%0d_v_walls", i), v, mv);
      check_output($sformatf("vec%0d_latency", i), cyc, msteps);
      check_output($sformatf("vec%0d_latency_bound", i), cyc <= 1262, 1);
      if (i == 0) begin
        for (int y = 0; y < H; y++) begin
          vl[y] = v[y*(W+1)];
          vr[y] = v[y*(W+1)+W];
        end
        check_output("border_h_top", h[W-1:0], {W{1'b1}});
        check_output("border_h_bottom", h[W*(H+1)-1:W*H], {W{1'b1}});
        check_output("border_v_left", vl, {H{1'b1}});
        check_output("border_v_right", vr, {H{1'b1}});
        check_output("row0_corridor", v[W-1:1], 0);
        check_output("cleared_count", $countones(~h) + $countones(~v), W*H - 1);
        check_output("bfs_reach", reach_count(h, v), W*H);
        repeat (3) @(negedge clk);
        check_output("walls_stable_idle", {bus.h_walls, bus.v_walls}, {h, v});
      end
    end

    model_run(16'h1234, mh, mv, msteps, evc, evb);
    apply_stimulus(32'h0000_1234, 20, -1, 0, h, v, cyc);
    check_output("restart_ignored_h", h, mh);
    check_output("restart_ignored_v", v, mv);
    check_output("restart_ignored_latency", cyc, msteps);

    @(negedge clk);
    bus.seed = 32'h0000_1234; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (49) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check_output("midrun_reset_busy_done", {bus.busy, bus.done}, 0);
    check_output("midrun_reset_h", bus.h_walls, {160{1'b1}});
    check_output("midrun_reset_v", bus.v_walls, {165{1'b1}});
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(32'h0000_1234, -1, -1, 0, h, v, cyc);
    check_output("after_reset_h", h, mh);
    check_output("after_reset_v", v, mv);
    check_output("after_reset_latency", cyc, msteps);

    for (int r = 0; r < 6; r++) begin
      s  = $urandom;
      ld = s[31:16] ^ s[15:0];
      if (ld == 16'h0) ld = 16'hACE1;
      model_run(ld, mh, mv, msteps, evc, evb);
      apply_stimulus(s, -1, evc, evb, h, v, cyc);
      check_output($sformatf("rand%0d_h_walls", r), h, mh);
      check_output($sformatf("rand%0d_v_walls", r), v, mv);
      check_output($sformatf("rand%0d_latency", r), cyc, msteps);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
